// File: rtl/icache_l1_pkg.sv
// Shared definitions for the L1 I-cache set memory: FSM encoding, default geometry
// and a width helper used by every file of the block.
package icache_l1_pkg;

   localparam int unsigned DefSets  = 16;
   localparam int unsigned DefWays  = 2;
   localparam int unsigned DefLineW = 16;
   localparam int unsigned DefTagW  = 20;

   typedef enum logic {
      StIdle  = 1'b0,
      StFlush = 1'b1
   } state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      int unsigned v;
      res = 0;
      v   = (value > 0) ? value - 1 : 0;
      while (v > 0) begin
         res = res + 1;
         v   = v >> 1;
      end
      return res;
   endfunction

   // Select fields never shrink to zero bits, even for a direct-mapped cache.
   function automatic int unsigned sel_width(input int unsigned n);
      return (n > 1) ? clog2(n) : 1;
   endfunction

endpackage

// File: rtl/icache_l1_set_mem_if.sv
// Request/response bundle between the I-cache controller (master) and the set memory (slave).
interface icache_l1_set_mem_if
   import icache_l1_pkg::*;
#(
   parameter int unsigned SETS   = DefSets,
   parameter int unsigned WAYS   = DefWays,
   parameter int unsigned LINE_W = DefLineW,
   parameter int unsigned TAG_W  = DefTagW
) ();

   localparam int unsigned IDX_W = clog2(SETS);
   localparam int unsigned WAY_W = sel_width(WAYS);

   logic              req_valid;
   logic              req_ready;
   logic              req_wr;
   logic [IDX_W-1:0]  req_index;
   logic [TAG_W-1:0]  req_tag;
   logic [WAY_W-1:0]  req_way;
   logic [LINE_W-1:0] req_data;
   logic              flush;
   logic              flush_busy;
   logic              rsp_valid;
   logic              rsp_hit;
   logic [WAY_W-1:0]  rsp_way;
   logic [LINE_W-1:0] rsp_data;

   modport master (
      output req_valid, req_wr, req_index, req_tag, req_way, req_data, flush,
      input  req_ready, flush_busy, rsp_valid, rsp_hit, rsp_way, rsp_data
   );

   modport slave (
      input  req_valid, req_wr, req_index, req_tag, req_way, req_data, flush,
      output req_ready, flush_busy, rsp_valid, rsp_hit, rsp_way, rsp_data
   );

endinterface

// File: rtl/icache_l1_way_array.sv
// One cache way: data, tag and valid arrays with a combinational tag compare on the read index.
module icache_l1_way_array
   import icache_l1_pkg::*;
#(
   parameter int unsigned SETS   = DefSets,
   parameter int unsigned LINE_W = DefLineW,
   parameter int unsigned TAG_W  = DefTagW,
   localparam int unsigned IDX_W = clog2(SETS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_index,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [LINE_W-1:0] wr_data,
   input  logic              clr_en,
   input  logic [IDX_W-1:0]  clr_index,
   input  logic [IDX_W-1:0]  rd_index,
   input  logic [TAG_W-1:0]  rd_tag,
   output logic              rd_hit,
   output logic [LINE_W-1:0] rd_data
);

   logic [LINE_W-1:0] data_mem [SETS];
   logic [TAG_W-1:0]  tag_mem  [SETS];
   logic [SETS-1:0]   valid_q;

   // Payload arrays are plain storage; only the valid bits need a defined reset value.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_mem[wr_index] <= wr_data;
         tag_mem[wr_index]  <= wr_tag;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else if (clr_en) begin
         valid_q[clr_index] <= 1'b0;
      end else if (wr_en) begin
         valid_q[wr_index] <= 1'b1;
      end
   end

   always_comb begin
      rd_hit  = valid_q[rd_index] && (tag_mem[rd_index] == rd_tag);
      rd_data = data_mem[rd_index];
   end

endmodule

// File: rtl/icache_l1_set_mem.sv
// N-way set-associative I-cache storage: parallel tag lookup with a registered result,
// single-way fills, and a one-set-per-cycle flush sweep.
module icache_l1_set_mem
   import icache_l1_pkg::*;
#(
   parameter int unsigned SETS   = DefSets,
   parameter int unsigned WAYS   = DefWays,
   parameter int unsigned LINE_W = DefLineW,
   parameter int unsigned TAG_W  = DefTagW
) (
   input logic               clk,
   input logic               rst,
   icache_l1_set_mem_if.slave bus
);

   localparam int unsigned IDX_W = clog2(SETS);
   localparam int unsigned WAY_W = sel_width(WAYS);
   localparam logic [IDX_W-1:0] LastSet = IDX_W'(SETS - 1);

   state_e            state;
   logic [IDX_W-1:0]  cnt;
   logic              flush_busy_q;
   logic              rsp_valid_q;
   logic              rsp_hit_q;
   logic [WAY_W-1:0]  rsp_way_q;
   logic [LINE_W-1:0] rsp_data_q;

   logic              accept;
   logic              lookup;
   logic              sweeping;
   logic [WAYS-1:0]   fill_en;
   logic [WAYS-1:0]   way_hit;
   logic [LINE_W-1:0] way_data [WAYS];
   logic              hit_any;
   logic [WAY_W-1:0]  hit_way;
   logic [LINE_W-1:0] hit_data;

   assign bus.req_ready = (state == StIdle) && !bus.flush;
   assign accept        = bus.req_valid && bus.req_ready;
   assign lookup        = accept && !bus.req_wr;
   assign sweeping      = (state == StFlush);

   // A fill naming a non-existent way matches no fill_en bit and is silently dropped.
   for (genvar g = 0; g < WAYS; g++) begin : g_way
      assign fill_en[g] = accept && bus.req_wr && (bus.req_way == WAY_W'(g));

      icache_l1_way_array #(
         .SETS   (SETS),
         .LINE_W (LINE_W),
         .TAG_W  (TAG_W)
      ) u_way (
         .clk       (clk),
         .rst       (rst),
         .wr_en     (fill_en[g]),
         .wr_index  (bus.req_index),
         .wr_tag    (bus.req_tag),
         .wr_data   (bus.req_data),
         .clr_en    (sweeping),
         .clr_index (cnt),
         .rd_index  (bus.req_index),
         .rd_tag    (bus.req_tag),
         .rd_hit    (way_hit[g]),
         .rd_data   (way_data[g])
      );
   end

   // Walk from the top way down so the lowest matching way ends up selected.
   always_comb begin
      hit_any  = |way_hit;
      hit_way  = '0;
      hit_data = '0;
      for (int w = int'(WAYS) - 1; w >= 0; w--) begin
         if (way_hit[w]) begin
            hit_way  = WAY_W'(w);
            hit_data = way_data[w];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_hit_q   <= 1'b0;
         rsp_way_q   <= '0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= lookup;
         if (lookup) begin
            rsp_hit_q  <= hit_any;
            rsp_way_q  <= hit_way;
            rsp_data_q <= hit_data;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= StIdle;
         cnt          <= '0;
         flush_busy_q <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (bus.flush) begin
                  state        <= StFlush;
                  flush_busy_q <= 1'b1;
               end
            end
            StFlush: begin
               if (cnt == LastSet) begin
                  cnt          <= '0;
                  state        <= StIdle;
                  flush_busy_q <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state        <= StIdle;
               flush_busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.flush_busy = flush_busy_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_hit    = rsp_hit_q;
   assign bus.rsp_way    = rsp_way_q;
   assign bus.rsp_data   = rsp_data_q;

endmodule
